fwd_operand_mux: RTL and testbench

Parametrised, registered operand-select stage for the pipelined MIPS datapath. Selects one operand from the register-file read value and NUM_SRC-1 forwarding sources by address match and fixed priority. Detects load-use hazards on a not-yet-ready source and registers the result with stall/flush control. Sits at the ID/EX boundary and replaces the fixed 3-input combinational forwarding select.

---
 rtl/fwd_operand_mux.sv | 86 ++++++++
 tb/tb_fwd_operand_mux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_operand_mux.sv
// Registered ID/EX operand select: register file plus prioritised forwarding sources, load-use hazard detect.
// Optional statistics counters are built when FWD_OPERAND_STATS_EN is defined.
module fwd_operand_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int ADDR_W  = 5,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [ADDR_W-1:0]             rs_addr,
    input  logic [WIDTH-1:0]              rf_data,
    input  logic [NUM_SRC-2:0]            fwd_valid,
    input  logic [NUM_SRC-2:0]            fwd_pending,
    input  logic [(NUM_SRC-1)*ADDR_W-1:0] fwd_addr,
    input  logic [(NUM_SRC-1)*WIDTH-1:0]  fwd_data,
    input  logic                          stall,
    input  logic                          flush,
    output logic                          hazard,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [SEL_W-1:0]              out_sel,
    output logic [15:0]                   fwd_count,
    output logic [15:0]                   hazard_count
);

    logic [SEL_W-1:0] win_sel;
    logic [WIDTH-1:0] win_data;
    logic             win_pend;
    logic             accept;

    // Walk from lowest priority upward so the youngest matching source overwrites older ones.
    always_comb begin
        win_sel  = '0;
        win_data = rf_data;
        win_pend = 1'b0;
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            if (fwd_valid[k-1] && (rs_addr != '0) &&
                (fwd_addr[(k-1)*ADDR_W +: ADDR_W] == rs_addr)) begin
                win_sel  = SEL_W'(k);
                win_data = fwd_data[(k-1)*WIDTH +: WIDTH];
                win_pend = fwd_pending[k-1];
            end
        end
    end

    assign hazard = in_valid & win_pend;
    assign accept = in_valid & ~hazard & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= win_sel;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FWD_OPERAND_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_count    <= '0;
            hazard_count <= '0;
        end else begin
            if (accept && (win_sel != '0) && (fwd_count != 16'hFFFF))
                fwd_count <= fwd_count + 16'd1;
            if (hazard && (hazard_count != 16'hFFFF))
                hazard_count <= hazard_count + 16'd1;
        end
    end
`else
    assign fwd_count    = 16'd0;
    assign hazard_count = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_operand_mux.sv
// Scoreboard bench for fwd_operand_mux: stimulus queues expected operands, a monitor checks each new output.
module tb_fwd_operand_mux;
    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 3;
    localparam int ADDR_W  = 5;
    localparam int SEL_W   = 2;
`ifdef FWD_OPERAND_STATS_EN
    localparam int STREAM_N = 65540;
`else
    localparam int STREAM_N = 6;
`endif

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b1;
    logic                          in_valid = 1'b0;
    logic [ADDR_W-1:0]             rs_addr = '0;
    logic [WIDTH-1:0]              rf_data = '0;
    logic [NUM_SRC-2:0]            fwd_valid = '0;
    logic [NUM_SRC-2:0]            fwd_pending = '0;
    logic [(NUM_SRC-1)*ADDR_W-1:0] fwd_addr = '0;
    logic [(NUM_SRC-1)*WIDTH-1:0]  fwd_data = '0;
    logic                          stall = 1'b0;
    logic                          flush = 1'b0;
    logic                          hazard;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_data;
    logic [SEL_W-1:0]              out_sel;
    logic [15:0]                   fwd_count;
    logic [15:0]                   hazard_count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+SEL_W-1:0] exp_q[$];
    logic [15:0] hc0, fc0;

    fwd_operand_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .rs_addr(rs_addr),
        .rf_data(rf_data), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall(stall), .flush(flush),
        .hazard(hazard), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .fwd_count(fwd_count), .hazard_count(hazard_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        exp_q.push_back({d, s});
    endtask

    task automatic set_fwd(input logic [1:0] v, input logic [1:0] p,
                           input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] d1, input logic [31:0] d2);
        fwd_valid   = v;
        fwd_pending = p;
        fwd_addr    = {a2, a1};
        fwd_data    = {d2, d1};
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Monitor: a new operand appears after an edge where neither stall nor flush was applied.
    initial begin
        logic s_st, s_fl;
        logic [WIDTH+SEL_W-1:0] e;
        forever begin
            @(posedge clk);
            s_st = stall;
            s_fl = flush;
            #1;
            if (reset_n && out_valid && !s_st && !s_fl) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %h sel %0d, expected none", out_data, out_sel);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[WIDTH+SEL_W-1:SEL_W]);
                    check("out_sel", {30'd0, out_sel}, {30'd0, e[SEL_W-1:0]});
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sel", {30'd0, out_sel}, 32'd0);
        check("rst_fwd_count", {16'd0, fwd_count}, 32'd0);
        check("rst_hazard_count", {16'd0, hazard_count}, 32'd0);
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();

        // Plain register-file read
        in_valid = 1'b1; rs_addr = 5'd5; rf_data = 32'h1111_0000;
        push(32'h1111_0000, 2'd0);
        #1 check("hazard_rf", {31'd0, hazard}, 32'd0);
        cyc();

        // Priority between two matching sources, then fallback to older, then no match
        set_fwd(2'b11, 2'b00, 5'd5, 5'd5, 32'hAAAA_0001, 32'hBBBB_0002);
        push(32'hAAAA_0001, 2'd1);
        cyc();
        fwd_valid = 2'b10;
        push(32'hBBBB_0002, 2'd2);
        cyc();
        set_fwd(2'b11, 2'b00, 5'd6, 5'd7, 32'hAAAA_0001, 32'hBBBB_0002);
        push(32'h1111_0000, 2'd0);
        cyc();

        // Register zero never forwards
        rs_addr = 5'd0; rf_data = 32'h2222_0000;
        set_fwd(2'b01, 2'b00, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0);
        push(32'h2222_0000, 2'd0);
        cyc();

        // Pending match without a request raises no hazard
        in_valid = 1'b0; rs_addr = 5'd5;
        set_fwd(2'b01, 2'b01, 5'd5, 5'd0, 32'hCAFE_0001, 32'h0);
        #1 check("hazard_no_req", {31'd0, hazard}, 32'd0);
        cyc();

        // Load-use: two hazard cycles, then delivery
        hc0 = hazard_count; fc0 = fwd_count;
        in_valid = 1'b1;
        #1 check("hazard_lu1", {31'd0, hazard}, 32'd1);
        cyc();
        check("bubble_lu1", {31'd0, out_valid}, 32'd0);
        #1 check("hazard_lu2", {31'd0, hazard}, 32'd1);
        cyc();
        check("bubble_lu2", {31'd0, out_valid}, 32'd0);
        fwd_pending = 2'b00;
        push(32'hCAFE_0001, 2'd1);
        #1 check("hazard_lu_clear", {31'd0, hazard}, 32'd0);
        cyc();
`ifdef FWD_OPERAND_STATS_EN
        check("lu_hazard_count", {16'd0, hazard_count - hc0}, 32'd2);
        check("lu_fwd_count", {16'd0, fwd_count - fc0}, 32'd1);
`endif

        // Pending on a lower-priority match is ignored
        set_fwd(2'b11, 2'b10, 5'd5, 5'd5, 32'hCAFE_0002, 32'hBAD0_0000);
        push(32'hCAFE_0002, 2'd1);
        #1 check("hazard_lowprio", {31'd0, hazard}, 32'd0);
        cyc();

        // Stall holds, stall+flush kills
        rs_addr = 5'd3; fwd_valid = 2'b00; rf_data = 32'h5555_AAAA;
        push(32'h5555_AAAA, 2'd0);
        cyc();
        stall = 1'b1; rf_data = 32'h6666_0000;
        repeat (3) begin
            cyc();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", out_data, 32'h5555_AAAA);
        end
        flush = 1'b1;
        cyc();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_data_hold", out_data, 32'h5555_AAAA);
        stall = 1'b0; flush = 1'b0;

        // Back-to-back accepts alternating sources
        rs_addr = 5'd8;
        for (int i = 0; i < 4; i++) begin
            rf_data = 32'h7000_0000 + i;
            if (i % 2 == 1) begin
                set_fwd(2'b10, 2'b00, 5'd0, 5'd8, 32'h0, 32'h8000_0000 + i);
                push(32'h8000_0000 + i, 2'd2);
            end else begin
                set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
                push(32'h7000_0000 + i, 2'd0);
            end
            cyc();
        end

        // Long forwarded stream, then asynchronous reset between edges
        rs_addr = 5'd9;
        set_fwd(2'b01, 2'b00, 5'd9, 5'd0, 32'h1234_5678, 32'h0);
        for (int n = 0; n < STREAM_N; n++) begin
            push(32'h1234_5678, 2'd1);
            cyc();
        end
`ifdef FWD_OPERAND_STATS_EN
        check("fwd_count_sat", {16'd0, fwd_count}, 32'h0000_FFFF);
`endif
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_sel", {30'd0, out_sel}, 32'd0);
        check("arst_fwd_count", {16'd0, fwd_count}, 32'd0);
        check("arst_hazard_count", {16'd0, hazard_count}, 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
